// File: rtl/videotext_pipelined_pkg.sv
// Shared constants for the videotext renderer: default text geometry, attribute
// bit position and the built-in 4x8 hex-digit font used for glyph codes 0..15.
package videotext_pipelined_pkg;

  localparam int DEF_COLS    = 40;
  localparam int DEF_ROWS    = 16;
  localparam int DEF_GLYPH_W = 4;
  localparam int DEF_GLYPH_H = 8;
  localparam int FONT_CODES  = 16;

  function automatic int attr_bit(input int d);
    return d - 1;
  endfunction

  // Row 0 of each glyph sits in the top nibble; the nibble MSB is the leftmost pixel.
  function automatic logic [3:0] font_row(input logic [3:0] code, input logic [2:0] line);
    logic [31:0] glyph;
    logic [31:0] shifted;
    case (code)
      4'h0:    glyph = 32'h69999960;
      4'h1:    glyph = 32'h26222270;
      4'h2:    glyph = 32'h691248F0;
      4'h3:    glyph = 32'hE11611E0;
      4'h4:    glyph = 32'h999F1110;
      4'h5:    glyph = 32'hF88E11E0;
      4'h6:    glyph = 32'h688E9960;
      4'h7:    glyph = 32'hF1124440;
      4'h8:    glyph = 32'h69969960;
      4'h9:    glyph = 32'h69971160;
      4'hA:    glyph = 32'h699F9990;
      4'hB:    glyph = 32'hE99E99E0;
      4'hC:    glyph = 32'h69888960;
      4'hD:    glyph = 32'hE99999E0;
      4'hE:    glyph = 32'hF88E88F0;
      default: glyph = 32'hF88E8880;
    endcase
    shifted = glyph << {line, 2'b00};
    return shifted[31:28];
  endfunction

endpackage

// File: rtl/videotext_pipelined_font.sv
// Combinational glyph lookup: (code, line) -> one row of GLYPH_W pixels, MSB leftmost.
// The 4x8 base font is stretched or decimated to the configured glyph size.
module text_font_rom
  import videotext_pipelined_pkg::*;
#(
  parameter int GLYPH_W = 4,
  parameter int GLYPH_H = 8,
  parameter int CW      = 7
) (
  input  logic [CW-1:0]              i_code,
  input  logic [$clog2(GLYPH_H)-1:0] i_line,
  output logic [GLYPH_W-1:0]         o_bits
);

  logic [2:0] w_src_line;
  logic [3:0] w_row;

  assign w_src_line = 3'((32'(i_line) * 8) / GLYPH_H);
  assign w_row      = font_row(i_code[3:0], w_src_line);

  // NOTE: o_bits gets a default before any branch so no latch is inferred.
  always_comb begin
    o_bits = '0;
    if (32'(i_code) < FONT_CODES) begin
      for (int j = 0; j < GLYPH_W; j++) begin
        o_bits[j] = w_row[2'(3 - ((GLYPH_W - 1 - j) * 4) / GLYPH_W)];
      end
    end
  end

endmodule

// File: rtl/videotext_pipelined.sv
// Text-mode renderer: beam position -> character RAM address -> glyph pixel, with
// inverse attribute, blinking block cursor and syncs delayed to match the pixel.
module videotext_pipelined
  import videotext_pipelined_pkg::*;
#(
  parameter int A            = 10,
  parameter int D            = 8,
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int GLYPH_W      = DEF_GLYPH_W,
  parameter int GLYPH_H      = DEF_GLYPH_H,
  parameter int HW           = 8,
  parameter int VW           = 7,
  parameter int RAM_LAT      = 1,
  parameter int BLINK_FRAMES = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [HW-1:0] hpos,
  input  logic [VW-1:0] vpos,
  input  logic          display_on,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [D-1:0]  dout,
  output logic [A-1:0]  vaddr,
  input  logic          cursor_we,
  input  logic [7:0]    cursor_col,
  input  logic [7:0]    cursor_row,
  input  logic          cursor_en,
  output logic          hsync,
  output logic          vsync,
  output logic          pixel
);

  localparam int XW = $clog2(GLYPH_W);
  localparam int YW = $clog2(GLYPH_H);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  if (COLS * ROWS > 2 ** A) begin : g_bad_size
    $error("COLS*ROWS does not fit in the character RAM address space");
  end
  if (RAM_LAT < 1 || RAM_LAT > 3 || BLINK_FRAMES < 1) begin : g_bad_timing
    $error("RAM_LAT must be 1..3 and BLINK_FRAMES at least 1");
  end
  if (GLYPH_W < 2 || GLYPH_H < 2 || (1 << XW) != GLYPH_W || (1 << YW) != GLYPH_H) begin : g_bad_glyph
    $error("glyph dimensions must be powers of two, at least 2");
  end

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          in_text;
    logic          disp;
    logic          hs;
    logic          vs;
    logic          hit;
  } stage_t;

  logic [HW-XW-1:0] w_col;
  logic [VW-YW-1:0] w_row;
  logic             w_in_text;
  logic             w_hit;
  logic [A-1:0]     w_addr;
  stage_t           w_s0;
  stage_t           w_last;
  logic [GLYPH_W-1:0] w_glyph;
  logic             w_font_bit;

  stage_t       r_pipe [RAM_LAT+1];
  logic [A-1:0] r_vaddr;
  logic [7:0]   r_cur_col;
  logic [7:0]   r_cur_row;
  logic [FW-1:0] r_frame;
  logic         r_blink_on;
  logic         r_vs_prev;
  logic         r_pixel;
  logic         r_hsync;
  logic         r_vsync;

  assign w_col     = hpos[HW-1:XW];
  assign w_row     = vpos[VW-1:YW];
  assign w_in_text = (32'(w_col) < COLS) && (32'(w_row) < ROWS);
  assign w_addr    = A'(32'(w_row) * COLS + 32'(w_col));
  assign w_hit     = cursor_en && (32'(w_col) == 32'(r_cur_col)) &&
                     (32'(w_row) == 32'(r_cur_row)) && r_blink_on;

  assign w_s0 = '{x: hpos[XW-1:0], y: vpos[YW-1:0], in_text: w_in_text,
                  disp: display_on, hs: hsync_in, vs: vsync_in, hit: w_hit};

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value and the delay line shifts by one per cycle.
  // NOTE: the delay-line array is reset explicitly so a mid-frame reset flushes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RAM_LAT; i++) r_pipe[i] <= '0;
      r_vaddr <= '0;
    end else begin
      r_pipe[0] <= w_s0;
      for (int i = 1; i <= RAM_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      r_vaddr <= w_in_text ? w_addr : '0;
    end
  end

  // Cursor moves take effect for the very next beam sample; blink counts frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_col  <= '0;
      r_cur_row  <= '0;
      r_frame    <= '0;
      r_blink_on <= 1'b1;
      r_vs_prev  <= 1'b0;
    end else begin
      if (cursor_we && (32'(cursor_col) < COLS) && (32'(cursor_row) < ROWS)) begin
        r_cur_col <= cursor_col;
        r_cur_row <= cursor_row;
      end
      r_vs_prev <= r_pipe[0].vs;
      if (r_pipe[0].vs && !r_vs_prev) begin
        if (r_frame == FW'(BLINK_FRAMES - 1)) begin
          r_frame    <= '0;
          r_blink_on <= ~r_blink_on;
        end else begin
          r_frame <= r_frame + 1'b1;
        end
      end
    end
  end

  assign w_last = r_pipe[RAM_LAT];

  text_font_rom #(
    .GLYPH_W (GLYPH_W),
    .GLYPH_H (GLYPH_H),
    .CW      (D - 1)
  ) u_font (
    .i_code (dout[D-2:0]),
    .i_line (w_last.y),
    .o_bits (w_glyph)
  );

  assign w_font_bit = w_glyph[XW'(GLYPH_W - 1) - w_last.x];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_pixel <= w_last.disp && w_last.in_text &&
                 (w_font_bit ^ dout[attr_bit(D)] ^ w_last.hit);
      r_hsync <= w_last.hs;
      r_vsync <= w_last.vs;
    end
  end

  assign vaddr = r_vaddr;
  assign pixel = r_pixel;
  assign hsync = r_hsync;
  assign vsync = r_vsync;

endmodule

// File: tb/tb_videotext_pipelined.sv
// Scoreboard bench: a cell/glyph reference model predicts every output cycle for
// RAM_LAT=1 and RAM_LAT=3 instances plus the address map of an 80x30 instance.
module tb_videotext_pipelined;

  localparam int LAT1 = 3;
  localparam int LAT3 = 5;
  localparam int BF   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset;
  logic [7:0] hpos;
  logic [6:0] vpos;
  logic       display_on, hsync_in, vsync_in, cursor_we, cursor_en;
  logic [7:0] cursor_col, cursor_row;
  logic [9:0] hpos_b;
  logic [8:0] vpos_b;

  logic [9:0]  vaddr1, vaddr3;
  logic [11:0] vaddr_b;
  logic [7:0]  dout1, dout3, dout_b;
  logic hsync1, vsync1, pixel1, hsync3, vsync3, pixel3, hsync_b, vsync_b, pixel_b;

  logic [7:0] mem [1024];
  logic [7:0] ram3 [3];

  always @(posedge clk) dout1 <= mem[vaddr1];
  always @(posedge clk) begin
    ram3[0] <= mem[vaddr3];
    ram3[1] <= ram3[0];
    ram3[2] <= ram3[1];
  end
  assign dout3  = ram3[2];
  assign dout_b = 8'h00;

  videotext_pipelined #(.RAM_LAT(1), .BLINK_FRAMES(BF)) dut1 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dout(dout1), .vaddr(vaddr1),
    .cursor_we(cursor_we), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_en(cursor_en), .hsync(hsync1), .vsync(vsync1), .pixel(pixel1));

  videotext_pipelined #(.RAM_LAT(3), .BLINK_FRAMES(BF)) dut3 (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dout(dout3), .vaddr(vaddr3),
    .cursor_we(cursor_we), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_en(cursor_en), .hsync(hsync3), .vsync(vsync3), .pixel(pixel3));

  videotext_pipelined #(.A(12), .COLS(80), .ROWS(30), .GLYPH_W(8), .GLYPH_H(16),
                        .HW(10), .VW(9)) dut_b (
    .clk(clk), .reset(reset), .hpos(hpos_b), .vpos(vpos_b), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .dout(dout_b), .vaddr(vaddr_b),
    .cursor_we(cursor_we), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .cursor_en(cursor_en), .hsync(hsync_b), .vsync(vsync_b), .pixel(pixel_b));

  // Hex digits 0..F, 4 pixels wide, 8 lines; line 0 is the top nibble, MSB leftmost.
  logic [31:0] tb_font [16] = '{
    32'h69999960, 32'h26222270, 32'h691248F0, 32'hE11611E0,
    32'h999F1110, 32'hF88E11E0, 32'h688E9960, 32'hF1124440,
    32'h69969960, 32'h69971160, 32'h699F9990, 32'hE99E99E0,
    32'h69888960, 32'hE99999E0, 32'hF88E88F0, 32'hF88E8880};

  typedef struct { int due; logic pix; logic hs; logic vs; } exp_t;
  typedef struct { int due; int addr; } aexp_t;
  exp_t  q1[$], q3[$];
  aexp_t qa[$], qb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Staged stimulus for the next beam sample.
  logic s_rst, s_disp, s_hs, s_vs, s_cwe, s_cen;
  int   s_h, s_v, s_cc, s_cr, s_hb, s_vb;

  // Reference state: cursor, frame counter, blink phase, vsync history.
  int   m_ccol, m_crow, m_frame;
  logic m_blink, vs_p1, vs_p2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic font_px(input logic [3:0] code, input int line, input int px);
    logic [31:0] w;
    w = tb_font[code];
    return w[31 - 4 * line - px];
  endfunction

  task automatic quiet();
    s_rst = 0; s_h = 200; s_v = 0; s_disp = 0; s_hs = 0; s_vs = 0;
    s_cwe = 0; s_cc = 0; s_cr = 0; s_cen = 0; s_hb = 0; s_vb = 0;
  endtask

  task automatic model_reset();
    m_ccol = 0; m_crow = 0; m_frame = 0; m_blink = 1'b1; vs_p1 = 1'b0; vs_p2 = 1'b0;
  endtask

  // Drive one beam sample and enqueue what the outputs must show for it.
  task automatic tick();
    int k, col, row, x, y, addr, colb, rowb, addrb;
    logic in_text, hit, fb, pix;
    logic [7:0] b;
    @(negedge clk);
    reset = s_rst; hpos = 8'(s_h); vpos = 7'(s_v); display_on = s_disp;
    hsync_in = s_hs; vsync_in = s_vs; cursor_we = s_cwe; cursor_col = 8'(s_cc);
    cursor_row = 8'(s_cr); cursor_en = s_cen; hpos_b = 10'(s_hb); vpos_b = 9'(s_vb);
    k = cyc;
    if (s_rst) begin
      while (q1.size() > 0 && q1[$].due > k) void'(q1.pop_back());
      while (q3.size() > 0 && q3[$].due > k) void'(q3.pop_back());
      for (int d = k + 1; d <= k + LAT1; d++) q1.push_back('{d, 1'b0, 1'b0, 1'b0});
      for (int d = k + 1; d <= k + LAT3; d++) q3.push_back('{d, 1'b0, 1'b0, 1'b0});
      qa.push_back('{k + 1, 0});
      qb.push_back('{k + 1, 0});
      model_reset();
    end else begin
      col = s_h / 4; x = s_h % 4; row = s_v / 8; y = s_v % 8;
      in_text = (col < 40) && (row < 16);
      addr = in_text ? row * 40 + col : 0;
      b = mem[addr];
      fb = (b[6:0] < 7'd16) ? font_px(b[3:0], y, x) : 1'b0;
      hit = s_cen && (col == m_ccol) && (row == m_crow) && m_blink;
      pix = s_disp && in_text && (fb ^ b[7] ^ hit);
      q1.push_back('{k + LAT1, pix, s_hs, s_vs});
      q3.push_back('{k + LAT3, pix, s_hs, s_vs});
      qa.push_back('{k + 1, addr});
      colb = s_hb / 8; rowb = s_vb / 16;
      addrb = (colb < 80 && rowb < 30) ? rowb * 80 + colb : 0;
      qb.push_back('{k + 1, addrb});
      if (vs_p1 && !vs_p2) begin
        if (m_frame == BF - 1) begin
          m_frame = 0;
          m_blink = !m_blink;
        end else begin
          m_frame++;
        end
      end
      vs_p2 = vs_p1;
      vs_p1 = s_vs;
      if (s_cwe && s_cc < 40 && s_cr < 16) begin
        m_ccol = s_cc;
        m_crow = s_cr;
      end
    end
  endtask

  task automatic scan_cell(input int c, input int r, input int lines);
    for (int v = r * 8; v < r * 8 + lines; v++) begin
      for (int h = c * 4; h < c * 4 + 8; h++) begin
        s_h = h; s_v = v; s_disp = 1; s_cen = 1;
        tick();
      end
    end
  endtask

  // Monitor: compare whatever the DUTs present against the entries due now.
  initial begin
    exp_t  e;
    aexp_t a;
    forever begin
      @(negedge clk);
      while (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        check("lat1.pixel", 32'(pixel1), 32'(e.pix));
        check("lat1.hsync", 32'(hsync1), 32'(e.hs));
        check("lat1.vsync", 32'(vsync1), 32'(e.vs));
      end
      while (q3.size() > 0 && q3[0].due <= cyc) begin
        e = q3.pop_front();
        check("lat3.pixel", 32'(pixel3), 32'(e.pix));
        check("lat3.hsync", 32'(hsync3), 32'(e.hs));
        check("lat3.vsync", 32'(vsync3), 32'(e.vs));
      end
      while (qa.size() > 0 && qa[0].due <= cyc) begin
        a = qa.pop_front();
        check("lat1.vaddr", 32'(vaddr1), 32'(a.addr));
      end
      while (qb.size() > 0 && qb[0].due <= cyc) begin
        a = qb.pop_front();
        check("big.vaddr", 32'(vaddr_b), 32'(a.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'($urandom);
    model_reset();
    quiet(); s_rst = 1;
    repeat (3) tick();

    // Address map, out-of-range column, large configuration.
    quiet(); s_disp = 1; s_h = 9; s_v = 17; s_hb = 639; s_vb = 479; tick();
    s_h = 160; s_hb = 640; tick();
    quiet(); repeat (4) tick();

    // Single-cycle hsync pulse through both latencies.
    s_hs = 1; tick();
    s_hs = 0; repeat (8) tick();

    // Glyph code 1 at cell (0,0) line 0, then the same with the inverse bit.
    mem[0] = 8'h01;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 1; d >= 0; d--) begin
        for (int h = 0; h < 4; h++) begin
          s_h = h; s_v = 0; s_disp = logic'(d); tick();
        end
      end
      quiet(); repeat (6) tick();
      mem[0] = 8'h81;
    end
    mem[0] = 8'h05;

    // Cursor blink over four frames, then an out-of-range write.
    s_rst = 1; tick();
    quiet(); s_cwe = 1; s_cc = 3; s_cr = 2; s_cen = 1; tick();
    quiet();
    for (int f = 0; f < 4; f++) begin
      scan_cell(3, 2, 8);
      quiet(); s_vs = 1; tick();
      s_vs = 0; tick();
    end
    s_cwe = 1; s_cc = 45; s_cr = 2; s_cen = 1; tick();
    quiet(); s_vs = 1; tick();
    s_vs = 0; tick();
    scan_cell(3, 2, 2);

    // Reset in the middle of active text, then cursor back at (0,0).
    s_h = 13; s_v = 17; s_disp = 1; s_cen = 1; s_rst = 1; tick();
    s_rst = 0;
    scan_cell(0, 0, 2);
    scan_cell(3, 2, 1);

    // Randomized traffic, biased towards the cursor cell.
    repeat (1500) begin
      s_rst  = ($urandom_range(0, 299) == 0);
      s_disp = ($urandom_range(0, 7) != 0);
      s_hs   = ($urandom_range(0, 7) == 0);
      s_vs   = ($urandom_range(0, 15) == 0);
      s_cwe  = ($urandom_range(0, 31) == 0);
      s_cc   = $urandom_range(0, 50);
      s_cr   = $urandom_range(0, 20);
      s_cen  = ($urandom_range(0, 3) != 0);
      s_hb   = $urandom_range(0, 1023);
      s_vb   = $urandom_range(0, 511);
      if ($urandom_range(0, 3) == 0) begin
        s_h = m_ccol * 4 + $urandom_range(0, 3);
        s_v = m_crow * 8 + $urandom_range(0, 7);
      end else begin
        s_h = $urandom_range(0, 255);
        s_v = $urandom_range(0, 127);
      end
      tick();
    end
    quiet(); tick();

    repeat (LAT3 + 1) @(negedge clk);
    #1;
    check("lat1.queue_drained", 32'(q1.size()), 32'd0);
    check("lat3.queue_drained", 32'(q3.size()), 32'd0);
    check("vaddr.queue_drained", 32'(qa.size() + qb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
